// File: rtl/econet_rx_ctrl_if.sv
// Econet receive-controller bus: receiver/FCS stream in, CPU frame handshake out.
interface econet_rx_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [7:0]      rx_byte;
  logic            rx_byte_ready;
  logic            rx_frame_start;
  logic            rx_frame_end;
  logic [15:0]     rx_fcs;
  logic [7:0]      station_id;
  logic            promisc;
  logic [ADDR_W-1:0] buf_raddr;
  logic [7:0]      buf_rdata;
  logic            frame_valid;
  logic [ADDR_W:0] frame_len;
  logic            frame_ack;
  logic [7:0]      err_count;
  logic [7:0]      drop_count;

  modport master (
    output rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs,
           station_id, promisc, buf_raddr, frame_ack,
    input  buf_rdata, frame_valid, frame_len, err_count, drop_count
  );

  modport slave (
    input  rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs,
           station_id, promisc, buf_raddr, frame_ack,
    output buf_rdata, frame_valid, frame_len, err_count, drop_count
  );
endinterface

// File: rtl/econet_rx_ctrl.sv
// Econet receive frame controller: destination filter, single-frame buffer,
// FCS/length check, CPU valid/ack handoff and saturating error/drop counters.
module econet_rx_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned MIN_LEN  = 6,
  parameter logic [15:0] FCS_GOOD = 16'hF0B8,
  parameter logic [7:0]  BCAST_ID = 8'hFF
) (
  input logic             econet_clk,
  input logic             reset,
  econet_rx_ctrl_if.slave bus
);

  localparam logic [ADDR_W:0] MIN_L = (ADDR_W+1)'(MIN_LEN);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_DISCARD, S_CHECK, S_HOLD} state_t;

  state_t          state_q;
  logic [ADDR_W:0] wr_ptr_q;
  logic            frame_valid_q;
  logic [ADDR_W:0] frame_len_q;
  logic [7:0]      err_q;
  logic [7:0]      drop_q;
  logic [7:0]      rdata_q;
  logic [7:0]      mem [2**ADDR_W];

  logic byte_in;
  logic overrun;
  logic filtered;
  logic wr_en;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Classify the byte strobed this cycle while receiving (restart has priority).
  always_comb begin
    byte_in  = (state_q == S_RECV) && bus.rx_byte_ready && !bus.rx_frame_start;
    overrun  = byte_in && wr_ptr_q[ADDR_W];
    filtered = byte_in && !wr_ptr_q[ADDR_W] && (wr_ptr_q == '0) && !bus.promisc &&
               (bus.rx_byte != bus.station_id) && (bus.rx_byte != BCAST_ID);
    wr_en    = byte_in && !wr_ptr_q[ADDR_W];
  end

  // Frame buffer write port (contents not reset).
  always_ff @(posedge econet_clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= bus.rx_byte;
  end

  // CPU read port, one cycle latency, independent of state.
  always_ff @(posedge econet_clk or negedge reset) begin
    if (!reset) rdata_q <= '0;
    else        rdata_q <= mem[bus.buf_raddr];
  end

  // Frame state machine with registered handshake outputs and counters.
  always_ff @(posedge econet_clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
      err_q         <= '0;
      drop_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.rx_frame_start) begin
            state_q  <= S_RECV;
            wr_ptr_q <= '0;
          end
        end
        S_RECV: begin
          if (bus.rx_frame_start) begin
            wr_ptr_q <= '0;
          end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (overrun) err_q <= sat_inc(err_q);
            // A rejected byte coinciding with the closing flag ends the frame outright.
            if (bus.rx_frame_end)        state_q <= (overrun || filtered) ? S_IDLE : S_CHECK;
            else if (overrun || filtered) state_q <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (bus.rx_frame_start) begin
            state_q  <= S_RECV;
            wr_ptr_q <= '0;
          end else if (bus.rx_frame_end) begin
            state_q <= S_IDLE;
          end
        end
        S_CHECK: begin
          if ((wr_ptr_q < MIN_L) || (bus.rx_fcs != FCS_GOOD)) begin
            state_q <= S_IDLE;
            err_q   <= sat_inc(err_q);
          end else begin
            state_q       <= S_HOLD;
            frame_valid_q <= 1'b1;
            frame_len_q   <= wr_ptr_q - (ADDR_W+1)'(2);
          end
        end
        S_HOLD: begin
          if (bus.frame_ack) begin
            frame_valid_q <= 1'b0;
            if (bus.rx_frame_start) begin
              state_q  <= S_RECV;
              wr_ptr_q <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (bus.rx_frame_start) begin
            drop_q <= sat_inc(drop_q);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.buf_rdata   = rdata_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_len   = frame_len_q;
  assign bus.err_count   = err_q;
  assign bus.drop_count  = drop_q;

endmodule
